// File: rtl/health_pkg.sv
// Shared types, geometry constants and arithmetic helpers for the health-bar controller.
package health_pkg;

  typedef logic [6:0] hp_t;

  typedef enum logic [0:0] {
    RUN = 1'b0,
    KO  = 1'b1
  } state_t;

  localparam hp_t        HP_MAX         = 7'd100;
  localparam logic [7:0] FILL_COL0_DIVE = 8'd36;
  localparam logic [7:0] FILL_COL0_KICK = 8'd8;
  localparam logic [9:0] BAR_W          = 10'd144;
  localparam logic [9:0] BAR_H          = 10'd12;
  localparam logic [5:0] TRANSPARENT    = 6'd63;
  localparam logic [7:0] PEND_MAX       = 8'd127;

  // a - b, clamped at zero
  function automatic logic [7:0] sub_clamp8(input logic [7:0] a, input logic [7:0] b);
    return (a > b) ? (a - b) : 8'd0;
  endfunction

  // both operands are at most 127, so the 8-bit sum cannot wrap before the clamp
  function automatic logic [7:0] sat_add127(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] sum;
    sum = a + b;
    return (sum > PEND_MAX) ? PEND_MAX : sum;
  endfunction

  // fill position f -> live, draining or lost colour
  function automatic logic [5:0] fill_pick(input logic [7:0] f, input hp_t hp, input hp_t disp,
                                           input logic [5:0] c_fill, input logic [5:0] c_drain,
                                           input logic [5:0] c_empty);
    if (f < {1'b0, hp}) begin
      return c_fill;
    end else if (f < {1'b0, disp}) begin
      return c_drain;
    end else begin
      return c_empty;
    end
  endfunction

endpackage

// File: rtl/health_bar_ctrl_if.sv
// Game-logic side of the health-bar controller: frame strobe, hits, health and KO status.
interface health_bar_ctrl_if;
  import health_pkg::*;

  logic       frame_clk;
  logic       round_reset;
  logic       dive_hit;
  logic       kick_hit;
  logic [6:0] dive_dmg;
  logic [6:0] kick_dmg;
  hp_t        dive_hp;
  hp_t        kick_hp;
  logic       dive_ko;
  logic       kick_ko;

  modport master (
    output frame_clk, round_reset, dive_hit, kick_hit, dive_dmg, kick_dmg,
    input  dive_hp, kick_hp, dive_ko, kick_ko
  );

  modport slave (
    input  frame_clk, round_reset, dive_hit, kick_hit, dive_dmg, kick_dmg,
    output dive_hp, kick_hp, dive_ko, kick_ko
  );

endinterface

// File: rtl/health_track.sv
// One player's health: pending-damage accumulator, per-frame health update, drain animation, KO flag.
module health_track
  import health_pkg::*;
#(
  parameter int DRAIN_STEP = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       hit,
  input  logic [6:0] dmg,
  input  logic       restore,
  input  logic       freeze,
  output hp_t        hp,
  output hp_t        disp,
  output logic       ko,
  output logic       zero_next
);

  logic [7:0] pend_r;
  logic [7:0] pend_next_s;
  logic [7:0] disp_dec_s;
  hp_t        hp_r;
  hp_t        disp_r;
  hp_t        hp_next_s;
  hp_t        disp_next_s;
  logic       ko_r;
  logic       ko_next_s;
  logic       take_s;

  // Next pending / health / displayed health / KO values; state only commits on a tick
  always_comb begin
    take_s = hit & ~freeze;

    // a hit coinciding with the tick opens the next frame's accumulator
    if (tick) begin
      pend_next_s = take_s ? {1'b0, dmg} : 8'd0;
    end else if (take_s) begin
      pend_next_s = sat_add127(pend_r, {1'b0, dmg});
    end else begin
      pend_next_s = pend_r;
    end

    if (restore) begin
      hp_next_s = HP_MAX;
    end else if (freeze) begin
      hp_next_s = hp_r;
    end else begin
      hp_next_s = hp_t'(sub_clamp8({1'b0, hp_r}, pend_r));
    end

    disp_dec_s = sub_clamp8({1'b0, disp_r}, 8'(DRAIN_STEP));
    if (restore) begin
      disp_next_s = HP_MAX;
    end else if (disp_r > hp_next_s) begin
      disp_next_s = (disp_dec_s > {1'b0, hp_next_s}) ? hp_t'(disp_dec_s) : hp_next_s;
    end else begin
      disp_next_s = hp_next_s;
    end

    if (restore) begin
      ko_next_s = 1'b0;
    end else if (!freeze && (hp_next_s == 7'd0)) begin
      ko_next_s = 1'b1;
    end else begin
      ko_next_s = ko_r;
    end

    zero_next = ~restore & ~freeze & (hp_next_s == 7'd0);
  end

  // Pending damage every cycle; health, drain and KO once per frame tick
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r <= 8'd0;
      hp_r   <= HP_MAX;
      disp_r <= HP_MAX;
      ko_r   <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      if (tick) begin
        hp_r   <= hp_next_s;
        disp_r <= disp_next_s;
        ko_r   <= ko_next_s;
      end
    end
  end

  assign hp   = hp_r;
  assign disp = disp_r;
  assign ko   = ko_r;

endmodule

// File: rtl/health_bar_ctrl.sv
// Health-bar controller: frame tick, round FSM shared by both players, and the registered pixel mapper.
module health_bar_ctrl
  import health_pkg::*;
#(
  parameter int DIVE_X0     = 16,
  parameter int KICK_X0     = 480,
  parameter int BAR_Y0      = 8,
  parameter int DRAIN_STEP  = 1,
  parameter int FILL_COLOR  = 5,
  parameter int DRAIN_COLOR = 20,
  parameter int EMPTY_COLOR = 0
) (
  input  logic              Clk,
  input  logic              Reset_n,
  health_bar_ctrl_if.slave  gif,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic [5:0]        dive_health_bar [0:11][0:143],
  input  logic [5:0]        kick_health_bar [0:11][0:143],
  output logic              bar_on,
  output logic [5:0]        bar_color
);

  localparam logic [5:0] C_FILL  = 6'(FILL_COLOR);
  localparam logic [5:0] C_DRAIN = 6'(DRAIN_COLOR);
  localparam logic [5:0] C_EMPTY = 6'(EMPTY_COLOR);
  localparam logic [7:0] KICK_F0 = FILL_COL0_KICK + 8'(HP_MAX) - 8'd1;

  logic   frame_prev_r;
  logic   tick_s;
  logic   rr_r;
  logic   restore_s;
  state_t state_r;
  state_t state_next_s;
  logic   freeze_s;

  hp_t  dive_hp_s, dive_disp_s, kick_hp_s, kick_disp_s;
  logic dive_ko_s, kick_ko_s, dive_zero_s, kick_zero_s;

  assign tick_s    = gif.frame_clk & ~frame_prev_r;
  assign restore_s = tick_s & (rr_r | gif.round_reset);

  // Frame-strobe edge history and the round_reset request latch (held until a tick consumes it)
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      frame_prev_r <= 1'b0;
      rr_r         <= 1'b0;
    end else begin
      frame_prev_r <= gif.frame_clk;
      if (tick_s) begin
        rr_r <= 1'b0;
      end else if (gif.round_reset) begin
        rr_r <= 1'b1;
      end
    end
  end

  // Round FSM state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_r <= RUN;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Round FSM next state, evaluated on frame ticks only
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      RUN: begin
        if (tick_s && !restore_s && (dive_zero_s || kick_zero_s)) begin
          state_next_s = KO;
        end else begin
          state_next_s = RUN;
        end
      end
      KO: begin
        if (restore_s) begin
          state_next_s = RUN;
        end else begin
          state_next_s = KO;
        end
      end
      default: state_next_s = RUN;
    endcase
  end

  // Round FSM outputs
  always_comb begin
    freeze_s = 1'b0;
    case (state_r)
      RUN:     freeze_s = 1'b0;
      KO:      freeze_s = 1'b1;
      default: freeze_s = 1'b0;
    endcase
  end

  health_track #(.DRAIN_STEP(DRAIN_STEP)) u_dive (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .tick      (tick_s),
    .hit       (gif.dive_hit),
    .dmg       (gif.dive_dmg),
    .restore   (restore_s),
    .freeze    (freeze_s),
    .hp        (dive_hp_s),
    .disp      (dive_disp_s),
    .ko        (dive_ko_s),
    .zero_next (dive_zero_s)
  );

  health_track #(.DRAIN_STEP(DRAIN_STEP)) u_kick (
    .clk       (Clk),
    .rst_n     (Reset_n),
    .tick      (tick_s),
    .hit       (gif.kick_hit),
    .dmg       (gif.kick_dmg),
    .restore   (restore_s),
    .freeze    (freeze_s),
    .hp        (kick_hp_s),
    .disp      (kick_disp_s),
    .ko        (kick_ko_s),
    .zero_next (kick_zero_s)
  );

  assign gif.dive_hp = dive_hp_s;
  assign gif.kick_hp = kick_hp_s;
  assign gif.dive_ko = dive_ko_s;
  assign gif.kick_ko = kick_ko_s;

  logic [9:0] dcol_s, kcol_s, row_s;
  logic       dive_in_s, kick_in_s;
  logic [5:0] dlbl_s, klbl_s;
  logic [7:0] df_s, kf_s;
  logic       on_next_s;
  logic [5:0] color_next_s;

  // Unsigned wrap makes "X < X0" land far above the bar width, so one compare covers both bounds
  assign dcol_s    = DrawX - 10'(DIVE_X0);
  assign kcol_s    = DrawX - 10'(KICK_X0);
  assign row_s     = DrawY - 10'(BAR_Y0);
  assign dive_in_s = (row_s < BAR_H) && (dcol_s < BAR_W);
  assign kick_in_s = (row_s < BAR_H) && (kcol_s < BAR_W);
  assign dlbl_s    = dive_health_bar[row_s[3:0]][dcol_s[7:0]];
  assign klbl_s    = kick_health_bar[row_s[3:0]][kcol_s[7:0]];
  assign df_s      = dcol_s[7:0] - FILL_COL0_DIVE;
  assign kf_s      = KICK_F0 - kcol_s[7:0];

  // Pixel colour selection: label first, then the health fill, else empty
  always_comb begin
    on_next_s    = 1'b0;
    color_next_s = 6'd0;
    if (dive_in_s) begin
      on_next_s = 1'b1;
      if (dlbl_s != TRANSPARENT) begin
        color_next_s = dlbl_s;
      end else if (df_s < 8'(HP_MAX)) begin
        color_next_s = fill_pick(df_s, dive_hp_s, dive_disp_s, C_FILL, C_DRAIN, C_EMPTY);
      end else begin
        color_next_s = C_EMPTY;
      end
    end else if (kick_in_s) begin
      on_next_s = 1'b1;
      if (klbl_s != TRANSPARENT) begin
        color_next_s = klbl_s;
      end else if (kf_s < 8'(HP_MAX)) begin
        color_next_s = fill_pick(kf_s, kick_hp_s, kick_disp_s, C_FILL, C_DRAIN, C_EMPTY);
      end else begin
        color_next_s = C_EMPTY;
      end
    end else begin
      on_next_s    = 1'b0;
      color_next_s = 6'd0;
    end
  end

  // Registered pixel outputs
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      bar_on    <= 1'b0;
      bar_color <= 6'd0;
    end else begin
      bar_on    <= on_next_s;
      bar_color <= color_next_s;
    end
  end

endmodule

// File: tb/tb_health_bar_ctrl.sv
// Directed plus random bench for health_bar_ctrl against a plain-arithmetic model of the rules.
module tb_health_bar_ctrl;
  import health_pkg::*;

  localparam int DX0 = 16;
  localparam int KX0 = 480;
  localparam int BY0 = 8;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic [9:0] DrawX = 10'd0;
  logic [9:0] DrawY = 10'd0;
  logic [5:0] dlbl [0:11][0:143];
  logic [5:0] klbl [0:11][0:143];
  logic       bar_on;
  logic [5:0] bar_color;

  always #5 Clk = ~Clk;

  health_bar_ctrl_if gif ();

  health_bar_ctrl #(
    .DIVE_X0(DX0), .KICK_X0(KX0), .BAR_Y0(BY0), .DRAIN_STEP(1),
    .FILL_COLOR(5), .DRAIN_COLOR(20), .EMPTY_COLOR(0)
  ) dut (
    .Clk             (Clk),
    .Reset_n         (Reset_n),
    .gif             (gif),
    .DrawX           (DrawX),
    .DrawY           (DrawY),
    .dive_health_bar (dlbl),
    .kick_health_bar (klbl),
    .bar_on          (bar_on),
    .bar_color       (bar_color)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  int m_dhp, m_khp, m_ddisp, m_kdisp, m_dpend, m_kpend;
  bit m_dko, m_kko, m_over, m_rr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic model_reset();
    m_dhp = 100; m_khp = 100; m_ddisp = 100; m_kdisp = 100;
    m_dpend = 0; m_kpend = 0; m_dko = 0; m_kko = 0; m_over = 0; m_rr = 0;
  endtask

  function automatic int drain(input int disp, input int hp);
    if (disp > hp) return (disp - 1 > hp) ? disp - 1 : hp;
    return hp;
  endfunction

  task automatic model_tick();
    if (m_rr) begin
      m_dhp = 100; m_khp = 100; m_ddisp = 100; m_kdisp = 100;
      m_dko = 0; m_kko = 0; m_over = 0; m_rr = 0;
    end else if (!m_over) begin
      m_dhp = (m_dhp > m_dpend) ? m_dhp - m_dpend : 0;
      m_khp = (m_khp > m_kpend) ? m_khp - m_kpend : 0;
      if (m_dhp == 0) m_dko = 1;
      if (m_khp == 0) m_kko = 1;
      if (m_dko || m_kko) m_over = 1;
    end
    m_ddisp = drain(m_ddisp, m_dhp);
    m_kdisp = drain(m_kdisp, m_khp);
    m_dpend = 0;
    m_kpend = 0;
  endtask

  task automatic model_hit(input bit kick, input int dmg);
    if (!m_over) begin
      if (kick) m_kpend = (m_kpend + dmg > 127) ? 127 : m_kpend + dmg;
      else      m_dpend = (m_dpend + dmg > 127) ? 127 : m_dpend + dmg;
    end
  endtask

  task automatic check_state(input string tag);
    chk({tag, ".dive_hp"}, 32'(gif.dive_hp), m_dhp);
    chk({tag, ".kick_hp"}, 32'(gif.kick_hp), m_khp);
    chk({tag, ".dive_ko"}, 32'(gif.dive_ko), 32'(m_dko));
    chk({tag, ".kick_ko"}, 32'(gif.kick_ko), 32'(m_kko));
  endtask

  task automatic do_frame(input string tag);
    gif.frame_clk = 1'b1;
    cyc();
    model_tick();
    gif.frame_clk = 1'b0;
    cyc();
    check_state(tag);
  endtask

  task automatic do_hit(input bit kick, input int dmg);
    if (kick) begin gif.kick_hit = 1'b1; gif.kick_dmg = 7'(dmg); end
    else      begin gif.dive_hit = 1'b1; gif.dive_dmg = 7'(dmg); end
    cyc();
    gif.kick_hit = 1'b0;
    gif.dive_hit = 1'b0;
    model_hit(kick, dmg);
  endtask

  task automatic hit_on_tick(input string tag, input bit kick, input int dmg);
    bit was_over;
    gif.frame_clk = 1'b1;
    if (kick) begin gif.kick_hit = 1'b1; gif.kick_dmg = 7'(dmg); end
    else      begin gif.dive_hit = 1'b1; gif.dive_dmg = 7'(dmg); end
    cyc();
    was_over = m_over;
    model_tick();
    if (!was_over) begin
      if (kick) m_kpend = dmg;
      else      m_dpend = dmg;
    end
    gif.kick_hit  = 1'b0;
    gif.dive_hit  = 1'b0;
    gif.frame_clk = 1'b0;
    cyc();
    check_state(tag);
  endtask

  task automatic do_rr();
    gif.round_reset = 1'b1;
    cyc();
    gif.round_reset = 1'b0;
    m_rr = 1;
  endtask

  function automatic int fill_ref(input int f, input int hp, input int disp);
    if (f < hp) return 5;
    if (f < disp) return 20;
    return 0;
  endfunction

  task automatic pix_ref(input int x, input int y, output int on, output int col);
    int c, r;
    on = 0; col = 0;
    r = y - BY0;
    if (r >= 0 && r < 12 && x >= DX0 && x < DX0 + 144) begin
      c = x - DX0; on = 1;
      if (dlbl[r][c] != 6'd63) col = int'(dlbl[r][c]);
      else if (c >= 36 && c < 136) col = fill_ref(c - 36, m_dhp, m_ddisp);
      else col = 0;
    end else if (r >= 0 && r < 12 && x >= KX0 && x < KX0 + 144) begin
      c = x - KX0; on = 1;
      if (klbl[r][c] != 6'd63) col = int'(klbl[r][c]);
      else if (c >= 8 && c < 108) col = fill_ref(107 - c, m_khp, m_kdisp);
      else col = 0;
    end
  endtask

  task automatic pix(input string tag, input int x, input int y);
    int on, col;
    DrawX = 10'(x);
    DrawY = 10'(y);
    cyc();
    pix_ref(x, y, on, col);
    chk({tag, ".on"}, 32'(bar_on), on);
    chk({tag, ".color"}, 32'(bar_color), col);
  endtask

  task automatic pixc(input string tag, input int x, input int y, input int on, input int col);
    DrawX = 10'(x);
    DrawY = 10'(y);
    cyc();
    chk({tag, ".on"}, 32'(bar_on), on);
    chk({tag, ".color"}, 32'(bar_color), col);
  endtask

  initial begin
    for (int r = 0; r < 12; r++) begin
      for (int c = 0; c < 144; c++) begin
        dlbl[r][c] = 6'd63;
        klbl[r][c] = 6'd63;
      end
    end
    dlbl[2][4] = 6'd61;
    for (int i = 0; i < 6; i++) begin
      dlbl[1][$urandom_range(0, 30)]   = 6'($urandom_range(0, 62));
      klbl[1][$urandom_range(110, 143)] = 6'($urandom_range(0, 62));
    end
    gif.frame_clk = 1'b0; gif.round_reset = 1'b0;
    gif.dive_hit = 1'b0; gif.kick_hit = 1'b0;
    gif.dive_dmg = 7'd0; gif.kick_dmg = 7'd0;
    model_reset();

    // reset state, with a pixel inside the dive fill held during reset
    DrawX = 10'(DX0 + 40); DrawY = 10'(BY0 + 5);
    Reset_n = 1'b0;
    cyc(); cyc(); cyc();
    chk("rst.bar_on", 32'(bar_on), 0);
    chk("rst.bar_color", 32'(bar_color), 0);
    check_state("rst");
    Reset_n = 1'b1;
    cyc();

    do_frame("first_tick");
    chk("first.dive_hp", 32'(gif.dive_hp), 100);
    pixc("fill_px", DX0 + 40, BY0 + 5, 1, 5);

    // two hits summed in one frame, then the drain trail
    do_hit(0, 30);
    do_hit(0, 15);
    do_frame("sum_hits");
    chk("sum.dive_hp", 32'(gif.dive_hp), 55);
    pixc("drain_mid", DX0 + 36 + 60, BY0 + 4, 1, 20);
    for (int i = 0; i < 43; i++) do_frame("drain_loop");
    pixc("drain44", DX0 + 36 + 55, BY0 + 4, 1, 20);
    do_frame("drain45");
    pixc("drain_done", DX0 + 36 + 55, BY0 + 4, 1, 0);
    pixc("fill_edge", DX0 + 36 + 54, BY0 + 4, 1, 5);

    // single KO, then hits are ignored
    do_hit(0, 45);
    do_frame("to10");
    do_hit(0, 25);
    do_frame("ko");
    chk("ko.dive_ko", 32'(gif.dive_ko), 1);
    chk("ko.dive_hp", 32'(gif.dive_hp), 0);
    do_hit(1, 5);
    do_frame("ko_frozen");
    chk("ko.kick_hp", 32'(gif.kick_hp), 100);
    do_rr();
    do_frame("ko_restore");
    chk("restore.dive_hp", 32'(gif.dive_hp), 100);

    // double KO
    do_hit(0, 95);
    do_hit(1, 95);
    do_frame("both5");
    do_hit(0, 5);
    do_hit(1, 5);
    do_frame("double_ko");
    chk("dko.dive_ko", 32'(gif.dive_ko), 1);
    chk("dko.kick_ko", 32'(gif.kick_ko), 1);
    do_rr();
    do_frame("dko_restore");
    chk("dko.kick_hp", 32'(gif.kick_hp), 100);
    chk("dko.kick_ko", 32'(gif.kick_ko), 0);

    // hit coinciding with the tick lands a frame later
    hit_on_tick("hit_on_tick", 0, 7);
    chk("hot.dive_hp", 32'(gif.dive_hp), 100);
    do_frame("hot_next");
    chk("hot_next.dive_hp", 32'(gif.dive_hp), 93);

    // label precedence and kick mirroring
    pixc("label", DX0 + 4, BY0 + 2, 1, 61);
    do_hit(1, 99);
    do_frame("kick1");
    for (int i = 0; i < 100; i++) do_frame("kdrain");
    pixc("kick_c107", KX0 + 107, BY0 + 3, 1, 5);
    pixc("kick_c106", KX0 + 106, BY0 + 3, 1, 0);
    pixc("right_edge_out", DX0 + 144, BY0, 0, 0);
    pixc("right_edge_in", DX0 + 143, BY0 + 11, 1, 0);
    pixc("left_out", DX0 - 1, BY0, 0, 0);
    pixc("below_out", DX0 + 40, BY0 + 12, 0, 0);

    // random traffic against the model
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 5))
        0: do_hit(0, int'($urandom_range(0, 60)));
        1: do_hit(1, int'($urandom_range(0, 60)));
        2: do_frame("rnd_frame");
        3: pix("rnd_pix", int'($urandom_range(0, 639)), int'($urandom_range(0, 23)));
        4: if ($urandom_range(0, 3) == 0) do_rr(); else do_frame("rnd_frame2");
        default: hit_on_tick("rnd_hot", 1'($urandom_range(0, 1)), int'($urandom_range(0, 30)));
      endcase
    end
    for (int i = 0; i < 10; i++) pix("rnd_bar", int'($urandom_range(DX0, DX0 + 143)), int'($urandom_range(BY0, BY0 + 11)));

    // reset mid-frame discards pending damage
    do_hit(0, 20);
    Reset_n = 1'b0;
    cyc();
    Reset_n = 1'b1;
    model_reset();
    do_frame("midreset");
    chk("midreset.dive_hp", 32'(gif.dive_hp), 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
